regfile_multi_ch: RTL

Parametrised PS-to-PL control/status register file serving NUM_CH DMA-style frame channels. Sits behind the AXI-Lite-to-memory-mapped bridge, using the same wr_*/rd_* strobe interface.
Adds to the single-channel block:
- per-channel register banks
- registered reads with a valid strobe
- a handshaked soft-reset FSM with timeout
- sticky W1C per-channel done status with a masked interrupt

---
 rtl/regfile_multi_ch_pkg.sv | 40 ++++
 rtl/rf_soft_reset_ctrl.sv | 68 ++++++
 rtl/regfile_multi_ch.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multi_ch_pkg.sv
// Shared definitions for the multi-channel frame DMA register file:
// register word indices, CTRL/STATUS/IRQ_EN bit positions, soft-reset FSM
// state encoding and the default identification constant.
package regfile_multi_ch_pkg;

  // Fixed register word indices (word index = byte address >> log2(bytes per word))
  localparam int REG_CTRL    = 0;
  localparam int REG_STATUS  = 1;
  localparam int REG_IRQ_EN  = 2;
  localparam int REG_ID      = 3;
  // First per-channel word; channel c owns words REG_CH_BASE+2c and REG_CH_BASE+2c+1
  localparam int REG_CH_BASE = 4;

  // Bit positions inside CTRL / STATUS / IRQ_EN
  localparam int CTRL_SRST_BIT      = 0;
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_TIMEOUT_BIT = 1;
  localparam int IRQ_TIMEOUT_BIT    = 1;
  // Per-channel fields (enable, done, done mask) start at this bit
  localparam int CH_FIELD_LSB       = 8;

  localparam logic [31:0] ID_DEFAULT = 32'h5246_0002;

  // Soft-reset handshake FSM encoding
  typedef logic [1:0] srst_state_t;
  localparam srst_state_t ST_IDLE      = 2'd0;
  localparam srst_state_t ST_ASSERT    = 2'd1;
  localparam srst_state_t ST_WAIT_DONE = 2'd2;

  // Word index of the CPU-writable read-side frame size for channel c
  function automatic int rd_fs_word(input int c);
    return REG_CH_BASE + 2 * c;
  endfunction

  // Word index of the read-only write-side frame size for channel c
  function automatic int wr_fs_word(input int num_ch, input int c);
    return REG_CH_BASE + 2 * num_ch + 2 * c;
  endfunction

endpackage

// File: rtl/rf_soft_reset_ctrl.sv
// Soft-reset handshake controller. A start request drives soft_reset for a
// fixed two-cycle assert phase, then keeps it high until the datapath reports
// reset_done or RST_TIMEOUT cycles pass, in which case a one-cycle
// timeout_set pulse is raised for the sticky STATUS bit.
module rf_soft_reset_ctrl
  import regfile_multi_ch_pkg::*;
#(
  parameter int RST_TIMEOUT = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic start,
  input  logic reset_done,
  output logic soft_reset,
  output logic busy,
  output logic timeout_set
);

  localparam int CNT_W = $clog2(RST_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(RST_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(1);

  srst_state_t       state;
  logic [CNT_W-1:0]  cnt;

  // State and phase counter; a start while not idle is simply not looked at
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ASSERT;
            cnt   <= '0;
          end
        end
        ST_ASSERT: begin
          if (cnt == ASSERT_LAST) begin
            state <= ST_WAIT_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (reset_done || (cnt == WAIT_LAST)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Decoded from state so the async reset drops soft_reset without a clock
  assign soft_reset  = (state != ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign timeout_set = (state == ST_WAIT_DONE) && !reset_done && (cnt == WAIT_LAST);

endmodule

// File: rtl/regfile_multi_ch.sv
// Multi-channel PS-to-PL control/status register file behind the AXI-Lite
// bridge strobe interface. Per-channel frame size / next address banks,
// registered reads, soft-reset handshake, sticky W1C done/timeout status and
// a masked level interrupt.
// Optional build macro REGFILE_SHADOW_EN: per-channel RW registers become
// shadows that are copied to the live outputs on ch_commit[c].
module regfile_multi_ch
  import regfile_multi_ch_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 8,
  parameter int          RST_TIMEOUT = 1024,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [NUM_CH*DATA_W-1:0] rd_frame_size,
  output logic [NUM_CH*DATA_W-1:0] rd_next_address,
  input  logic [NUM_CH*DATA_W-1:0] wr_frame_size,
  input  logic [NUM_CH*DATA_W-1:0] wr_next_address,
  input  logic [NUM_CH-1:0]        ch_done,
  input  logic [NUM_CH-1:0]        ch_commit,
  output logic [NUM_CH-1:0]        ch_enable,
  output logic                     soft_reset,
  input  logic                     reset_done,
  output logic                     irq
);

  localparam int BE_W     = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(BE_W);

  logic [31:0]        wr_idx;
  logic [31:0]        rd_idx;
  logic [DATA_W-1:0]  wr_mask;
  logic               wr_ctrl;
  logic               wr_status;
  logic               wr_irq_en;
  logic               srst_start;
  logic               busy;
  logic               timeout_set;

  logic [NUM_CH-1:0]  ch_en_q;
  logic [NUM_CH-1:0]  done_q;
  logic [NUM_CH-1:0]  done_mask_q;
  logic [NUM_CH-1:0]  done_clr;
  logic               timeout_q;
  logic               timeout_mask_q;
  logic               timeout_clr;

  logic [DATA_W-1:0]  fs_q   [NUM_CH];
  logic [DATA_W-1:0]  na_q   [NUM_CH];
  logic [DATA_W-1:0]  fs_d   [NUM_CH];
  logic [DATA_W-1:0]  na_d   [NUM_CH];
  logic [DATA_W-1:0]  fs_out [NUM_CH];
  logic [DATA_W-1:0]  na_out [NUM_CH];
  logic [DATA_W-1:0]  rd_mux;

  logic               unused_addr_bits;

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_v,
                                                 input logic [DATA_W-1:0] new_v,
                                                 input logic [DATA_W-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign wr_idx = 32'(wr_addr[ADDR_W-1:ADDR_LSB]);
  assign rd_idx = 32'(rd_addr[ADDR_W-1:ADDR_LSB]);
  assign unused_addr_bits = ^{wr_addr[ADDR_LSB-1:0], rd_addr[ADDR_LSB-1:0]};

  // Expand byte enables into a bit mask shared by every RW register
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < BE_W; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_be[b]}};
    end
  end

  assign wr_ctrl    = wr_en && (wr_idx == 32'(REG_CTRL));
  assign wr_status  = wr_en && (wr_idx == 32'(REG_STATUS));
  assign wr_irq_en  = wr_en && (wr_idx == 32'(REG_IRQ_EN));
  assign srst_start = wr_ctrl && wr_be[0] && wr_data[CTRL_SRST_BIT];

  assign done_clr    = wr_status ? (wr_data[CH_FIELD_LSB +: NUM_CH] & wr_mask[CH_FIELD_LSB +: NUM_CH])
                                 : '0;
  assign timeout_clr = wr_status && wr_mask[STATUS_TIMEOUT_BIT] && wr_data[STATUS_TIMEOUT_BIT];

  rf_soft_reset_ctrl #(
    .RST_TIMEOUT (RST_TIMEOUT)
  ) u_srst (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .start       (srst_start),
    .reset_done  (reset_done),
    .soft_reset  (soft_reset),
    .busy        (busy),
    .timeout_set (timeout_set)
  );

  // Channel enables and interrupt masks, byte-enable merged
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ch_en_q        <= '0;
      done_mask_q    <= '0;
      timeout_mask_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ch_en_q <= (ch_en_q & ~wr_mask[CH_FIELD_LSB +: NUM_CH])
                 | (wr_data[CH_FIELD_LSB +: NUM_CH] & wr_mask[CH_FIELD_LSB +: NUM_CH]);
      end
      if (wr_irq_en) begin
        done_mask_q <= (done_mask_q & ~wr_mask[CH_FIELD_LSB +: NUM_CH])
                     | (wr_data[CH_FIELD_LSB +: NUM_CH] & wr_mask[CH_FIELD_LSB +: NUM_CH]);
        if (wr_mask[IRQ_TIMEOUT_BIT]) begin
          timeout_mask_q <= wr_data[IRQ_TIMEOUT_BIT];
        end
      end
    end
  end

  // Sticky status: a new event in the same cycle as its W1C keeps the bit set
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= (done_q & ~done_clr) | ch_done;
      timeout_q <= (timeout_q & ~timeout_clr) | timeout_set;
    end
  end

  // Next value of the CPU-visible per-channel registers
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      fs_d[c] = fs_q[c];
      na_d[c] = na_q[c];
      if (wr_en && (wr_idx == 32'(rd_fs_word(c)))) begin
        fs_d[c] = be_merge(fs_q[c], wr_data, wr_mask);
      end
      if (wr_en && (wr_idx == 32'(rd_fs_word(c) + 1))) begin
        na_d[c] = be_merge(na_q[c], wr_data, wr_mask);
      end
    end
  end

  // CPU-visible per-channel registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        fs_q[c] <= '0;
        na_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        fs_q[c] <= fs_d[c];
        na_q[c] <= na_d[c];
      end
    end
  end

`ifdef REGFILE_SHADOW_EN
  // Live outputs pick up the shadow, including a same-cycle write, at commit
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        fs_out[c] <= '0;
        na_out[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_commit[c]) begin
          fs_out[c] <= fs_d[c];
          na_out[c] <= na_d[c];
        end
      end
    end
  end
`else
  logic unused_commit;
  assign unused_commit = ^ch_commit;

  // Without shadowing the live outputs are the registers themselves
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      fs_out[c] = fs_q[c];
      na_out[c] = na_q[c];
    end
  end
`endif

  // Pack per-channel outputs, channel 0 in the LSBs
  always_comb begin
    rd_frame_size   = '0;
    rd_next_address = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_frame_size[c*DATA_W +: DATA_W]   = fs_out[c];
      rd_next_address[c*DATA_W +: DATA_W] = na_out[c];
    end
  end

  assign ch_enable = ch_en_q;

  // Read decode; anything not matched falls through as zero
  always_comb begin
    rd_mux = '0;
    if (rd_idx == 32'(REG_CTRL)) begin
      rd_mux[CTRL_SRST_BIT]            = busy;
      rd_mux[CH_FIELD_LSB +: NUM_CH]   = ch_en_q;
    end else if (rd_idx == 32'(REG_STATUS)) begin
      rd_mux[STATUS_BUSY_BIT]          = busy;
      rd_mux[STATUS_TIMEOUT_BIT]       = timeout_q;
      rd_mux[CH_FIELD_LSB +: NUM_CH]   = done_q;
    end else if (rd_idx == 32'(REG_IRQ_EN)) begin
      rd_mux[IRQ_TIMEOUT_BIT]          = timeout_mask_q;
      rd_mux[CH_FIELD_LSB +: NUM_CH]   = done_mask_q;
    end else if (rd_idx == 32'(REG_ID)) begin
      rd_mux = DATA_W'(ID_VALUE);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_idx == 32'(rd_fs_word(c)))             rd_mux = fs_q[c];
      if (rd_idx == 32'(rd_fs_word(c) + 1))         rd_mux = na_q[c];
      if (rd_idx == 32'(wr_fs_word(NUM_CH, c)))     rd_mux = wr_frame_size[c*DATA_W +: DATA_W];
      if (rd_idx == 32'(wr_fs_word(NUM_CH, c) + 1)) rd_mux = wr_next_address[c*DATA_W +: DATA_W];
    end
  end

  // Registered read port, data held between reads
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

  // Level interrupt, one cycle behind the status bits
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      irq <= 1'b0;
    end else begin
      irq <= (|(done_q & done_mask_q)) | (timeout_q & timeout_mask_q);
    end
  end

endmodule
